// File: rtl/cache_fill_sequencer_if.sv
// cache_fill_sequencer_if: miss, victim and bus handshake bundle of the fill sequencer
interface cache_fill_sequencer_if #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 256,
  parameter int BUSW    = 64
);
  localparam int BEATW = $clog2(LINELEN / BUSW);
  logic               CacheMiss;
  logic               FlushStage;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimDirty;
  logic               BusReady;
  logic               BusRead;
  logic               BusWrite;
  logic [BEATW-1:0]   BeatCount;
  logic [NUMWAYS-1:0] FillWay;
  logic               FillWordEn;
  logic               SetValid;
  logic               ClearDirty;
  logic               LFSRWriteEn;
  logic               CacheStall;
  modport slave (
    input  CacheMiss, FlushStage, VictimWay, VictimDirty, BusReady,
    output BusRead, BusWrite, BeatCount, FillWay, FillWordEn,
           SetValid, ClearDirty, LFSRWriteEn, CacheStall
  );
  modport master (
    output CacheMiss, FlushStage, VictimWay, VictimDirty, BusReady,
    input  BusRead, BusWrite, BeatCount, FillWay, FillWordEn,
           SetValid, ClearDirty, LFSRWriteEn, CacheStall
  );
endinterface

// File: rtl/cache_fill_sequencer.sv
// cache_fill_sequencer: victim writeback, beat-wise line fill and replacement-state commit after a miss
module cache_fill_sequencer #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 256,
  parameter int BUSW    = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  cache_fill_sequencer_if.slave bus
);
  localparam int BEATS = LINELEN / BUSW;
  localparam int BEATW = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, COMMIT, REPLAY} state_t;
  state_t             state_q, state_d;
  logic [BEATW-1:0]   cnt_q, cnt_d;
  logic [NUMWAYS-1:0] way_q, way_d;
  logic               accept, last;
  assign accept = reset_n & (state_q == IDLE) & bus.CacheMiss & ~bus.FlushStage;
  assign last   = cnt_q == BEATW'(BEATS - 1);
  // state, beat counter and captured victim way
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
    end
  end
  // next-state: bus states advance only on completed beats and leave on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    way_d   = way_q;
    case (state_q)
      IDLE: if (accept) begin
        way_d   = bus.VictimWay;
        cnt_d   = '0;
        state_d = bus.VictimDirty ? WRITEBACK : FILL;
      end
      WRITEBACK: if (bus.BusReady) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? FILL : WRITEBACK;
      end
      FILL: if (bus.BusReady) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? COMMIT : FILL;
      end
      COMMIT:  state_d = REPLAY;
      default: state_d = IDLE;
    endcase
  end
  assign bus.BusRead     = reset_n & (state_q == FILL);
  assign bus.BusWrite    = reset_n & (state_q == WRITEBACK);
  assign bus.FillWordEn  = bus.BusRead & bus.BusReady;
  assign bus.SetValid    = reset_n & (state_q == COMMIT);
  assign bus.ClearDirty  = bus.SetValid;
  assign bus.LFSRWriteEn = bus.SetValid;
  assign bus.BeatCount   = reset_n ? cnt_q : '0;
  assign bus.FillWay     = reset_n ? way_q : '0;
  assign bus.CacheStall  = accept | bus.BusWrite | bus.BusRead | bus.SetValid;
endmodule

// File: tb/tb_cache_fill_sequencer.sv
// tb_cache_fill_sequencer: directed cycle-by-cycle checks of the cache fill sequencer
module tb_cache_fill_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   lfsr_n = 0;
  int   sv_n = 0;
  int   fwe_n = 0;
  cache_fill_sequencer_if #(.NUMWAYS(4), .LINELEN(256), .BUSW(64)) bus ();
  cache_fill_sequencer #(.NUMWAYS(4), .LINELEN(256), .BUSW(64)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.LFSRWriteEn) lfsr_n++;
    if (bus.SetValid) sv_n++;
    if (bus.FillWordEn) fwe_n++;
  end
  function automatic logic [12:0] e(input logic rd, input logic wr, input logic [1:0] cnt,
                                    input logic [3:0] way, input logic fwe, input logic cmt,
                                    input logic st);
    return {rd, wr, cnt, way, fwe, cmt, cmt, cmt, st};
  endfunction
  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    #1;
    obs = {bus.BusRead, bus.BusWrite, bus.BeatCount, bus.FillWay, bus.FillWordEn,
           bus.SetValid, bus.ClearDirty, bus.LFSRWriteEn, bus.CacheStall};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_onehot(input string tag);
    checks++;
    assert ($onehot(bus.VictimWay)) else begin
      errors++;
      $error("FAIL %s observed=%b expected=onehot", tag, bus.VictimWay);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  int l0;
  initial begin
    reset_n = 1'b0;
    bus.CacheMiss = 1'b1;
    bus.FlushStage = 1'b0;
    bus.VictimWay = 4'b0100;
    bus.VictimDirty = 1'b0;
    bus.BusReady = 1'b1;
    cyc();
    cyc();
    chk("reset_all_zero", e(0, 0, 2'd0, 4'b0000, 0, 0, 0));
    reset_n = 1'b1;
    bus.CacheMiss = 1'b0;
    cyc();
    chk("idle_after_reset", e(0, 0, 2'd0, 4'b0000, 0, 0, 0));
    l0 = lfsr_n;
    bus.CacheMiss = 1'b1;
    chk_onehot("clean_onehot");
    chk("clean_c0_stall", e(0, 0, 2'd0, 4'b0000, 0, 0, 1));
    cyc();
    bus.CacheMiss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clean_fill_%0d", i), e(1, 0, 2'(i), 4'b0100, 1, 0, 1));
      cyc();
    end
    chk("clean_commit_c5", e(0, 0, 2'd0, 4'b0100, 0, 1, 1));
    cyc();
    chk("clean_replay_c6", e(0, 0, 2'd0, 4'b0100, 0, 0, 0));
    cyc();
    chk("clean_idle_c7", e(0, 0, 2'd0, 4'b0100, 0, 0, 0));
    chk_int("clean_lfsr_pulses", lfsr_n - l0, 1);
    l0 = lfsr_n;
    bus.CacheMiss = 1'b1;
    bus.VictimWay = 4'b0001;
    bus.VictimDirty = 1'b1;
    chk_onehot("dirty_onehot");
    chk("dirty_c0_stall", e(0, 0, 2'd0, 4'b0100, 0, 0, 1));
    cyc();
    bus.CacheMiss = 1'b0;
    bus.VictimDirty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dirty_wb_%0d", i), e(0, 1, 2'(i), 4'b0001, 0, 0, 1));
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dirty_fill_%0d", i), e(1, 0, 2'(i), 4'b0001, 1, 0, 1));
      cyc();
    end
    chk("dirty_commit_c9", e(0, 0, 2'd0, 4'b0001, 0, 1, 1));
    cyc();
    bus.CacheMiss = 1'b1;
    bus.VictimWay = 4'b1000;
    chk("dirty_replay_ignores_miss", e(0, 0, 2'd0, 4'b0001, 0, 0, 0));
    chk_int("dirty_lfsr_pulses", lfsr_n - l0, 1);
    cyc();
    l0 = lfsr_n;
    fwe_n = 0;
    chk_onehot("b2b_onehot");
    chk("b2b_accept", e(0, 0, 2'd0, 4'b0001, 0, 0, 1));
    cyc();
    bus.CacheMiss = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.BusReady = (k % 2 == 0);
      if (k == 3) bus.VictimWay = 4'b0001;
      chk($sformatf("wait_fill_%0d", k), e(1, 0, 2'((k - 1) / 2), 4'b1000, k % 2 == 0, 0, 1));
      cyc();
    end
    bus.BusReady = 1'b1;
    chk("wait_commit", e(0, 0, 2'd0, 4'b1000, 0, 1, 1));
    chk_int("wait_fillworden_count", fwe_n, 4);
    cyc();
    chk("wait_replay", e(0, 0, 2'd0, 4'b1000, 0, 0, 0));
    cyc();
    chk_int("b2b_lfsr_pulses", lfsr_n - l0, 1);
    bus.CacheMiss = 1'b1;
    bus.FlushStage = 1'b1;
    bus.VictimWay = 4'b0010;
    chk("flush_blocks_accept", e(0, 0, 2'd0, 4'b1000, 0, 0, 0));
    cyc();
    chk("flush_stays_idle", e(0, 0, 2'd0, 4'b1000, 0, 0, 0));
    l0 = lfsr_n;
    bus.FlushStage = 1'b0;
    chk_onehot("rst_onehot");
    chk("rst_accept", e(0, 0, 2'd0, 4'b1000, 0, 0, 1));
    cyc();
    bus.CacheMiss = 1'b0;
    bus.FlushStage = 1'b1;
    chk("rst_fill_0_flush_ignored", e(1, 0, 2'd0, 4'b0010, 1, 0, 1));
    cyc();
    bus.FlushStage = 1'b0;
    chk("rst_fill_1", e(1, 0, 2'd1, 4'b0010, 1, 0, 1));
    cyc();
    chk("rst_fill_2", e(1, 0, 2'd2, 4'b0010, 1, 0, 1));
    reset_n = 1'b0;
    chk("rst_low_outputs_zero", e(0, 0, 2'd0, 4'b0000, 0, 0, 0));
    cyc();
    reset_n = 1'b1;
    chk("rst_next_idle", e(0, 0, 2'd0, 4'b0000, 0, 0, 0));
    for (int i = 0; i < 6; i++) cyc();
    chk("rst_still_idle", e(0, 0, 2'd0, 4'b0000, 0, 0, 0));
    chk_int("rst_no_lfsr", lfsr_n - l0, 0);
    chk_int("total_setvalid", sv_n, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_sequencer.md
# cache_fill_sequencer

Sequences cache line replacement after a miss. It sits directly downstream of the cache replacement-policy block: it captures that block's one-hot victim way. If the victim is dirty, it writes the victim back over the bus, then fills the line beat by beat. At the end it commits the fill and pulses the replacement-state update (`LFSRWriteEn`) so that the next victim choice advances.

## Interface
- `NUMWAYS`, 4: cache associativity; `VictimWay`/`FillWay` width.
- `LINELEN`, 256: line size in bits.
- `BUSW`, 64: bus beat width in bits. `BEATS = LINELEN/BUSW`, a power of two and ≥2. `BEATW = $clog2(BEATS)`.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `CacheMiss`  in  1  current access missed and needs a line.
- `FlushStage`  in  1  pipeline flush; blocks acceptance of a new miss.
- `VictimWay`  in  NUMWAYS  one-hot victim from the replacement block.
- `VictimDirty`  in  1  dirty bit of the victim line in the addressed set.
- `BusReady`  in  1  current bus beat completes this cycle.
- `BusRead`  out  1  fill beat request.
- `BusWrite`  out  1  writeback beat request.
- `BeatCount`  out  BEATW  index of the current beat within the line.
- `FillWay`  out  NUMWAYS  latched victim way, selects the data/tag array way.
- `FillWordEn`  out  1  write the returned beat `BeatCount` into `FillWay`.
- `SetValid`  out  1  set the valid bit of `FillWay`.
- `ClearDirty`  out  1  clear the dirty bit of `FillWay`.
- `LFSRWriteEn`  out  1  one-cycle pulse that advances the replacement state.
- `CacheStall`  out  1  stalls the pipeline while the miss is serviced.

## Operation
FSM states: IDLE, WRITEBACK, FILL, COMMIT, REPLAY.

- **IDLE**
  - Accept when `CacheMiss & ~FlushStage`.
  - On accept: latch `VictimWay` into `FillWay` and clear `BeatCount`.
  - Next state is WRITEBACK if `VictimDirty`, else FILL.
  - Without acceptance, stay in IDLE.
- **WRITEBACK**
  - `BusWrite=1`.
  - Each `BusReady` increments `BeatCount`.
  - `BusReady` on beat BEATS-1: `BeatCount` wraps to 0 and the FSM goes to FILL.
- **FILL**
  - `BusRead=1`; `FillWordEn = BusReady`.
  - `BeatCount` increments on each `BusReady`.
  - `BusReady` on beat BEATS-1: `BeatCount` wraps to 0 and the FSM goes to COMMIT.
- **COMMIT**
  - One cycle with `SetValid=1`, `ClearDirty=1`, `LFSRWriteEn=1`.
  - Next state is REPLAY.
- **REPLAY**
  - One cycle with `CacheStall=0`, so the pipeline replays the access, which now hits.
  - `CacheMiss` is ignored in this cycle.
  - Next state is IDLE.

Output rules:
- `CacheStall = (IDLE & CacheMiss & ~FlushStage) | WRITEBACK | FILL | COMMIT`.
- `FillWay` holds its value from acceptance until the next acceptance. Changes on `VictimWay` after acceptance have no effect.
- `FlushStage` during WRITEBACK, FILL or COMMIT is ignored, because a bus transfer cannot be aborted. It only gates acceptance in IDLE.
- `VictimWay` must be one-hot at acceptance. The bench asserts this; the RTL does not correct it.
- Exactly one `LFSRWriteEn` pulse per accepted miss; none otherwise.

## Timing
Reset (`reset_n` low at a rising edge):
- State becomes IDLE; `BeatCount=0`; `FillWay=0`.
- While `reset_n` is low, every output is forced to 0, including `CacheStall`, and no miss is accepted.

Reset mid-operation:
- Reset in any state returns to IDLE next cycle.
- No `SetValid` or `LFSRWriteEn` is issued for the abandoned miss.

Latency, with `BusReady` held high and the miss accepted at cycle 0:
- **Clean miss:** FILL in cycles 1..BEATS, COMMIT at BEATS+1, REPLAY at BEATS+2, IDLE at BEATS+3.
- **Dirty miss:** each state after acceptance occurs BEATS cycles later than for a clean miss (WRITEBACK in cycles 1..BEATS, FILL in BEATS+1..2·BEATS).

`BusReady` low cycles:
- Each one extends the current state by one cycle.
- `BeatCount` holds, and the request (`BusRead`/`BusWrite`) stays asserted.

Back-to-back misses:
- The earliest next acceptance is the cycle after REPLAY.
- The FSM is in IDLE in that cycle, so a new miss there is accepted.

Outputs:
- Counter, FSM and `FillWay` are registered.
- The remaining outputs are decoded combinationally from state, with `FillWordEn` and `CacheStall` also using inputs.

## Test plan
- **Clean miss** (`NUMWAYS=4`, `BEATS=4`, `VictimWay=4'b0100`, `VictimDirty=0`, `BusReady=1`):
  - `BusRead` for cycles 1–4; `FillWordEn` with `BeatCount` 0,1,2,3.
  - `SetValid`, `ClearDirty` and `LFSRWriteEn` high only in cycle 5, with `FillWay=4'b0100`.
  - `CacheStall` high in cycles 0–5 and low in cycle 6.
- **Dirty miss** (`VictimDirty=1`):
  - `BusWrite` for cycles 1–4, then `BusRead` for cycles 5–8.
  - COMMIT in cycle 9; exactly one `LFSRWriteEn` pulse.
- **Bus wait states** (`BusReady` low on every other cycle during FILL):
  - `BeatCount` advances only on ready cycles; FILL lasts 8 cycles.
  - `FillWordEn` is asserted exactly 4 times.
- **Flush and way capture:**
  - `CacheMiss=1` with `FlushStage=1` in IDLE: no acceptance, `CacheStall=0`.
  - Miss accepted, then `VictimWay` changed mid-fill: `FillWay` is unchanged.
- **Reset mid-fill:** `reset_n` low at `BeatCount=2` of FILL:
  - Next cycle: IDLE, `BeatCount=0`, all outputs 0.
  - No `SetValid` or `LFSRWriteEn` for that miss.
- **Back-to-back misses:** a second miss presented in the cycle after REPLAY is accepted; each miss produces exactly one `LFSRWriteEn` pulse.
